// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the binary-to-BCD converter
//
// Contents:
//   state_t         converter FSM encoding (IDLE=0, SHIFT=1)
//   BCD_ADJ_THRESH  digit value at which the shift-add-3 correction applies
//   BCD_ADJ_ADD     correction added to a digit before it is shifted
//   cnt_width()     iteration-count width for a given binary width
//   ITER_CNT_W      iteration-count width for the default 8-bit input
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Enough bits to count 0..w shifts.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int ITER_CNT_W = cnt_width(8);

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational "if >= 5 add 3" cell for one BCD digit
//
// Ports:
//   din   in  [3:0]  digit before correction
//   dout  out [3:0]  digit after correction, ready to be shifted left
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // A digit of 5..9 would become >= 10 when doubled; adding 3 first makes
  // the doubled value carry into the next digit as a proper decimal carry.
  always_comb begin
    dout = din;
    if (din >= BCD_ADJ_THRESH) begin
      dout = din + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin8_to_bcd.sv
// rtl/bin8_to_bcd.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
//
// Ports:
//   clk    in                rising-edge clock
//   rst    in                asynchronous active-high reset
//   start  in                conversion request, sampled only while idle
//   bin    in  [W_BIN-1:0]   binary value, captured on the accepting edge
//   bcd    out [4*N_DIG-1:0] packed digits (hundreds [11:8], tens [7:4], units [3:0])
//   busy   out               high while a conversion is running
//   done   out               one-cycle pulse when bcd has just been updated
//
// Build option BIN2BCD_CHANGE_TRIG_EN: when defined, a change of bin relative
// to the last accepted value also triggers a conversion while idle.
module bin8_to_bcd
  import bin2bcd_pkg::*;
#(
  parameter int W_BIN = 8,
  parameter int N_DIG = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W_BIN-1:0]     bin,
  output logic [4*N_DIG-1:0]   bcd,
  output logic                 busy,
  output logic                 done
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = cnt_width(W_BIN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W_BIN - 1);

  state_t             state;
  logic [W_BIN-1:0]   shreg;
  logic [BCD_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_next;
  logic [W_BIN-1:0]   sh_next;
  logic               trig;

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // {digits, shift reg} shifted left by one after digit correction.
  assign acc_next = {acc_adj[BCD_W-2:0], shreg[W_BIN-1]};
  assign sh_next  = {shreg[W_BIN-2:0], 1'b0};

`ifdef BIN2BCD_CHANGE_TRIG_EN
  logic [W_BIN-1:0] last_bin;
  assign trig = start | (bin != last_bin);
`else
  assign trig = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef BIN2BCD_CHANGE_TRIG_EN
      last_bin <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trig) begin
            shreg <= bin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef BIN2BCD_CHANGE_TRIG_EN
            last_bin <= bin;
`endif
          end
        end
        SHIFT: begin
          shreg <= sh_next;
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          // Final shift: publish the accumulator as it leaves this edge.
          if (cnt == LAST_CNT) begin
            bcd   <= acc_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin8_to_bcd.sv
// tb/tb_bin8_to_bcd.sv - scoreboard bench for bin8_to_bcd
module tb_bin8_to_bcd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int passed;
  int total;
  int cyc;
  int last_done_cyc;
  int n_done;
  bit prev_done;
  logic [11:0] exp_q[$];
  logic [7:0]  hist[$];
  bit          zero_seen;

  bin8_to_bcd #(.W_BIN(8), .N_DIG(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .bcd   (bcd),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    hist.push_back(bin);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compares every done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        logic [11:0] e;
        n_done++;
`ifdef BIN2BCD_CHANGE_TRIG_EN
        e = 12'h000;
        if (hist.size() >= 9) begin
          logic [7:0] v;
          v = hist[hist.size() - 9];
          e = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
          if (v == 8'd0) zero_seen = 1'b1;
        end
`else
        if (exp_q.size() == 0) begin
          e = 12'hfff;
          $display("FAIL unexpected_done: got bcd %0h, expected no done", bcd);
          total++;
        end else begin
          e = exp_q.pop_front();
        end
`endif
        check("bcd_on_done", {20'd0, bcd}, {20'd0, e});
        check("busy_low_on_done", {31'd0, busy}, 32'd0);
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (last_done_cyc >= 0)
          check("done_spacing_ge9", {31'd0, (cyc - last_done_cyc) >= 9}, 32'd1);
        last_done_cyc = cyc;
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      $display("FAIL wait_idle: got busy=%0b, expected idle within 40 cycles", busy);
      total++;
    end
  endtask

  // One start pulse accepted at the next edge; optionally scoreboarded.
  task automatic convert(input logic [7:0] v, input logic [11:0] e, input bit push);
    @(posedge clk);
    #1;
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    start = 1'b0;
  endtask

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    n_done = 0;
    last_done_cyc = -1;
    prev_done = 1'b0;
    zero_seen = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    bin = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_bcd", {20'd0, bcd}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef BIN2BCD_CHANGE_TRIG_EN
    // bin=0 equals the reset last_bin, so nothing should happen.
    begin
      int act;
      act = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy || done || bcd != 12'h000) act++;
      end
      check("idle_after_reset", act, 32'd0);
    end
    // Live free-running counter feeding bin, start held low.
    repeat (2400) begin
      @(posedge clk);
      #1 bin = bin + 8'd1;
    end
    wait_idle();
    check("wrap_zero_seen", {31'd0, zero_seen}, 32'd1);
    check("done_count_nonzero", {31'd0, n_done > 200}, 32'd1);
`else
    begin
      int act;
      act = 0;
      repeat (20) begin
        @(negedge clk);
        if (busy || done || bcd != 12'h000) act++;
      end
      check("idle_after_reset", act, 32'd0);
    end

    // 255: busy for exactly 8 sampled cycles.
    begin
      int nb;
      convert(8'd255, 12'h255, 1'b1);
      nb = 0;
      @(negedge clk);
      while (busy && nb < 20) begin
        nb++;
        @(negedge clk);
      end
      check("busy_cycles_255", nb, 32'd8);
    end
    wait_idle();

    // start held high across three back-to-back conversions.
    @(posedge clk);
    #1;
    bin = 8'd99;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(12'h099);
    #1 bin = 8'd128;
    repeat (9) @(posedge clk);
    exp_q.push_back(12'h128);
    #1 bin = 8'd10;
    repeat (9) @(posedge clk);
    exp_q.push_back(12'h010);
    #1 start = 1'b0;
    wait_idle();
    check("held_start_dones", n_done, 32'd4);

    // Re-pulse during a conversion of 200 with bin changed to 7.
    convert(8'd200, 12'h200, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    bin = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (15) @(negedge clk);
    check("no_second_conv_busy", {31'd0, busy}, 32'd0);
    check("ignored_trigger_dones", n_done, 32'd5);

    // Reset in the middle of a conversion of 173.
    convert(8'd173, 12'h173, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", n_done, 32'd5);
    check("scoreboard_empty", exp_q.size(), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule
